// File: rtl/conv_gpio_ctrl.sv
// conv_gpio_ctrl: GPIO command sequencer driving kernel regs, image memory and conv core with clean strobes.
// Define CONV_CTRL_ERR_EN to enable the sticky o_err flag for dropped strobes and write overflow.
module conv_gpio_ctrl #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10,
   parameter int K_ROWS = 3
) (
   input  logic              i_clock,
   input  logic              i_rst_n,
   input  logic [2:0]        i_GPIOctrl,
   input  logic              i_GPIOvalid,
   input  logic [DATA_W-1:0] i_GPIOdata,
   output logic              o_kernel_we,
   output logic [1:0]        o_kernel_sel,
   output logic [DATA_W-1:0] o_kernel_data,
   output logic [LEN_W-1:0]  o_img_len,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_waddr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_conv_start,
   input  logic              i_conv_done,
   output logic              o_mem_re,
   output logic [ADDR_W-1:0] o_mem_raddr,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0] o_GPIOdata,
   output logic              o_busy,
   output logic              o_err
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [2:0] C_KERNEL = 3'b000, C_LENGTH = 3'b001, C_IMAGE = 3'b010,
                          C_READ = 3'b011, C_LAST = 3'b100;
   state_t state, nxt;
   logic v_s1, v_s2, v_s3, stb, start_pend, re_d, w_full;
   logic idle_like, cmd_ok, do_kernel, do_last, do_write, do_read;
   logic [1:0] k_cnt;
   logic [ADDR_W-1:0] w_cnt, r_cnt;

   assign stb       = v_s2 & ~v_s3;
   // the cycle between a LAST write and entering RUN already counts as busy for new commands
   assign idle_like = state != RUN && !start_pend;
   assign cmd_ok    = stb && idle_like;
   assign do_kernel = cmd_ok && i_GPIOctrl == C_KERNEL;
   assign do_last   = cmd_ok && i_GPIOctrl == C_LAST;
   assign do_write  = cmd_ok && !w_full && (i_GPIOctrl == C_IMAGE || i_GPIOctrl == C_LAST);
   assign do_read   = cmd_ok && state == DONE && i_GPIOctrl == C_READ;
   assign o_busy    = state == RUN;

   always_ff @(posedge i_clock or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      if (start_pend) nxt = RUN;
      else if (state == RUN && i_conv_done) nxt = DONE;
   end

   always_ff @(posedge i_clock or negedge i_rst_n)
      if (!i_rst_n) begin
         {v_s3, v_s2, v_s1} <= '0;
         o_kernel_we   <= 1'b0;
         o_kernel_sel  <= '0;
         o_kernel_data <= '0;
         o_img_len     <= '0;
         o_mem_we      <= 1'b0;
         o_mem_waddr   <= '0;
         o_mem_wdata   <= '0;
         o_conv_start  <= 1'b0;
         o_mem_re      <= 1'b0;
         o_mem_raddr   <= '0;
         o_GPIOdata    <= '0;
         start_pend    <= 1'b0;
         re_d          <= 1'b0;
         w_full        <= 1'b0;
         k_cnt         <= '0;
         w_cnt         <= '0;
         r_cnt         <= '0;
      end else begin
         {v_s3, v_s2, v_s1} <= {v_s2, v_s1, i_GPIOvalid};
         o_kernel_we  <= do_kernel;
         o_mem_we     <= do_write;
         o_mem_re     <= do_read;
         re_d         <= o_mem_re;
         start_pend   <= do_last;
         o_conv_start <= start_pend;
         if (do_kernel) begin
            o_kernel_sel  <= k_cnt;
            o_kernel_data <= i_GPIOdata;
            k_cnt         <= k_cnt == 2'(K_ROWS - 1) ? 2'd0 : k_cnt + 2'd1;
         end
         if (i_GPIOctrl == C_LENGTH && state != RUN) o_img_len <= i_GPIOdata[LEN_W-1:0];
         // the top address is written once, then the buffer saturates instead of wrapping
         if (do_write) begin
            o_mem_waddr <= w_cnt;
            o_mem_wdata <= i_GPIOdata;
            w_full      <= &w_cnt;
            w_cnt       <= w_cnt + 1'b1;
         end
         if (start_pend) begin
            w_cnt  <= '0;
            r_cnt  <= '0;
            w_full <= 1'b0;
         end
         if (do_read) begin
            o_mem_raddr <= r_cnt;
            r_cnt       <= r_cnt + 1'b1;
         end
         if (re_d) o_GPIOdata <= i_mem_rdata;
      end

`ifdef CONV_CTRL_ERR_EN
   logic bad;
   assign bad = stb && (!idle_like || i_GPIOctrl inside {3'b101, 3'b110, 3'b111} ||
                (i_GPIOctrl == C_READ && state != DONE) ||
                ((i_GPIOctrl == C_IMAGE || i_GPIOctrl == C_LAST) && w_full));
   always_ff @(posedge i_clock or negedge i_rst_n)
      if (!i_rst_n) o_err <= 1'b0;
      else if (bad) o_err <= 1'b1;
      else if (do_kernel && state == IDLE) o_err <= 1'b0;
`else
   assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_conv_gpio_ctrl.sv
// tb_conv_gpio_ctrl: command-level model with strobe scoreboards for conv_gpio_ctrl.
// Expected o_err follows CONV_CTRL_ERR_EN when the bench is built with it.
module tb_conv_gpio_ctrl;
`ifdef CONV_CTRL_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam logic [2:0] KER = 3'b000, LEN = 3'b001, IMG = 3'b010, RD = 3'b011, LST = 3'b100;

   logic        i_clock = 1'b0, i_rst_n = 1'b0, i_GPIOvalid = 1'b0, i_conv_done = 1'b0;
   logic [2:0]  i_GPIOctrl = 3'b000;
   logic [23:0] i_GPIOdata = '0, i_mem_rdata = '0;
   logic        o_kernel_we, o_mem_we, o_conv_start, o_mem_re, o_busy, o_err;
   logic [1:0]  o_kernel_sel;
   logic [23:0] o_kernel_data, o_mem_wdata, o_GPIOdata;
   logic [9:0]  o_img_len, o_mem_waddr, o_mem_raddr;

   conv_gpio_ctrl dut (
      .i_clock(i_clock), .i_rst_n(i_rst_n), .i_GPIOctrl(i_GPIOctrl), .i_GPIOvalid(i_GPIOvalid),
      .i_GPIOdata(i_GPIOdata), .o_kernel_we(o_kernel_we), .o_kernel_sel(o_kernel_sel),
      .o_kernel_data(o_kernel_data), .o_img_len(o_img_len), .o_mem_we(o_mem_we),
      .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata), .o_conv_start(o_conv_start),
      .i_conv_done(i_conv_done), .o_mem_re(o_mem_re), .o_mem_raddr(o_mem_raddr),
      .i_mem_rdata(i_mem_rdata), .o_GPIOdata(o_GPIOdata), .o_busy(o_busy), .o_err(o_err)
   );

   always #5 i_clock = ~i_clock;

   always @(posedge i_clock) if (o_mem_re) i_mem_rdata <= 24'(o_mem_raddr) + 24'h100;

   int n_tests = 0, n_fail = 0;
   logic [25:0] exp_k[$];
   logic [33:0] exp_w[$];
   logic [9:0]  exp_r[$];
   int exp_start = 0;
   int mode = 0;
   int k_idx = 0, w_idx = 0, r_idx = 0;
   logic m_err = 1'b0;
   logic [23:0] m_gpio = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   int cyc = 0, last_we = -10;
   always @(negedge i_clock) begin
      cyc++;
      if (i_rst_n) begin
         if (o_kernel_we) begin
            if (exp_k.size() == 0) check("kernel_we_extra", 64'(o_kernel_we), 64'd0);
            else check("kernel_row", 64'({o_kernel_sel, o_kernel_data}), 64'(exp_k.pop_front()));
         end
         if (o_mem_we) begin
            last_we = cyc;
            if (exp_w.size() == 0) check("mem_we_extra", 64'(o_mem_we), 64'd0);
            else check("mem_write", 64'({o_mem_waddr, o_mem_wdata}), 64'(exp_w.pop_front()));
         end
         if (o_mem_re) begin
            if (exp_r.size() == 0) check("mem_re_extra", 64'(o_mem_re), 64'd0);
            else check("mem_raddr", 64'(o_mem_raddr), 64'(exp_r.pop_front()));
         end
         if (o_conv_start) begin
            if (exp_start == 0) check("start_extra", 64'(o_conv_start), 64'd0);
            else begin
               exp_start--;
               check("start_after_last_write", 64'(cyc - last_we), 64'd1);
               check("busy_at_start", 64'(o_busy), 64'd1);
            end
         end
      end
   end

   task automatic pulse(input logic [2:0] c, input logic [23:0] d);
      @(negedge i_clock);
      i_GPIOctrl = c;
      i_GPIOdata = d;
      i_GPIOvalid = 1'b1;
      repeat (4) @(negedge i_clock);
      i_GPIOvalid = 1'b0;
      repeat (3) @(negedge i_clock);
      #1;
   endtask

   task automatic send(input logic [2:0] c, input logic [23:0] d);
      logic legal;
      legal = mode != 1 && !(c inside {3'b101, 3'b110, 3'b111}) && !(c == RD && mode != 2);
      if (!legal) m_err = 1'b1;
      else if (c == KER) begin
         if (mode == 0) m_err = 1'b0;
         exp_k.push_back({2'(k_idx), d});
         k_idx = (k_idx + 1) % 3;
      end else if (c == IMG || c == LST) begin
         exp_w.push_back({10'(w_idx), d});
         w_idx++;
         if (c == LST) begin
            exp_start++;
            mode = 1;
            w_idx = 0;
            r_idx = 0;
         end
      end else if (c == RD) begin
         exp_r.push_back(10'(r_idx));
         m_gpio = 24'(r_idx) + 24'h100;
         r_idx++;
      end
      pulse(c, d);
      check("strobes_drained", 64'(exp_k.size() + exp_w.size() + exp_r.size() + exp_start), 64'd0);
   endtask

   task automatic model_reset();
      exp_k.delete();
      exp_w.delete();
      exp_r.delete();
      exp_start = 0;
      mode = 0;
      k_idx = 0;
      w_idx = 0;
      r_idx = 0;
      m_err = 1'b0;
      m_gpio = '0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_kernel_we"}, 64'(o_kernel_we), 64'd0);
      check({tag, "_kernel_sel"}, 64'(o_kernel_sel), 64'd0);
      check({tag, "_kernel_data"}, 64'(o_kernel_data), 64'd0);
      check({tag, "_img_len"}, 64'(o_img_len), 64'd0);
      check({tag, "_mem_we"}, 64'(o_mem_we), 64'd0);
      check({tag, "_mem_waddr"}, 64'(o_mem_waddr), 64'd0);
      check({tag, "_mem_wdata"}, 64'(o_mem_wdata), 64'd0);
      check({tag, "_conv_start"}, 64'(o_conv_start), 64'd0);
      check({tag, "_mem_re"}, 64'(o_mem_re), 64'd0);
      check({tag, "_mem_raddr"}, 64'(o_mem_raddr), 64'd0);
      check({tag, "_gpio_data"}, 64'(o_GPIOdata), 64'd0);
      check({tag, "_busy"}, 64'(o_busy), 64'd0);
      check({tag, "_err"}, 64'(o_err), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge i_clock);
      check_zero_outputs("reset");
      i_rst_n = 1'b1;
      repeat (2) @(negedge i_clock);

      send(RD, 24'h0);
      check("err_read_in_idle", 64'(o_err), 64'(ERR_EN & m_err));
      @(negedge i_clock) i_conv_done = 1'b1;
      @(negedge i_clock) i_conv_done = 1'b0;
      check("done_in_idle_busy", 64'(o_busy), 64'd0);

      send(KER, 24'h000);
      check("err_cleared_by_kernel", 64'(o_err), 64'(ERR_EN & m_err));
      send(KER, 24'h100);
      send(KER, 24'h000);
      check("kernel_sel_third", 64'(o_kernel_sel), 64'd2);
      send(KER, 24'h0AB);
      check("kernel_sel_wrap", 64'(o_kernel_sel), 64'd0);
      check("kernel_data_fourth", 64'(o_kernel_data), 64'h0AB);

      @(negedge i_clock);
      i_GPIOctrl = LEN;
      i_GPIOdata = 24'h009;
      repeat (3) @(negedge i_clock);
      check("img_len_level", 64'(o_img_len), 64'd9);
      i_GPIOctrl = IMG;
      i_GPIOdata = 24'h3FF;
      repeat (3) @(negedge i_clock);
      check("img_len_hold", 64'(o_img_len), 64'd9);

      for (int i = 0; i < 39; i++) send(IMG, 24'(i));
      send(LST, 24'h27);
      check("last_waddr", 64'(o_mem_waddr), 64'd39);
      check("last_wdata", 64'(o_mem_wdata), 64'h27);
      check("busy_in_run", 64'(o_busy), 64'd1);

      send(IMG, 24'h5A5);
      check("err_image_in_run", 64'(o_err), 64'(ERR_EN & m_err));
      check("busy_still_run", 64'(o_busy), 64'd1);
      @(negedge i_clock) i_conv_done = 1'b1;
      @(negedge i_clock) i_conv_done = 1'b0;
      mode = 2;
      check("busy_after_done", 64'(o_busy), 64'd0);

      for (int i = 0; i < 40; i++) begin
         send(RD, 24'h0);
         check("gpio_readback", 64'(o_GPIOdata), 64'(m_gpio));
      end
      check("gpio_last_read", 64'(o_GPIOdata), 64'h127);

      send(KER, 24'h0CD);
      check("err_kept_kernel_in_done", 64'(o_err), 64'(ERR_EN & m_err));

      send(IMG, 24'h55);
      send(LST, 24'h66);
      check("busy_second_run", 64'(o_busy), 64'd1);
      #2 i_rst_n = 1'b0;
      #1 check_zero_outputs("run_reset");
      model_reset();
      @(negedge i_clock) i_rst_n = 1'b1;
      repeat (10) @(negedge i_clock);
      check("busy_after_run_reset", 64'(o_busy), 64'd0);

      i_GPIOctrl = IMG;
      i_GPIOdata = 24'h77;
      i_GPIOvalid = 1'b1;
      repeat (2) @(negedge i_clock);
      #2 i_rst_n = 1'b0;
      #1 check_zero_outputs("valid_reset");
      i_GPIOvalid = 1'b0;
      repeat (2) @(negedge i_clock);
      i_rst_n = 1'b1;
      repeat (10) @(negedge i_clock);
      check("no_stray_write", 64'(o_mem_waddr), 64'd0);

      send(KER, 24'h0EE);
      check("kernel_sel_after_reset", 64'(o_kernel_sel), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
